// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by both ends of the ALU byte-serial command bus.
//   - opcode constants (4-bit opcode field)
//   - command state encoding used by the initiator FSM
//   - opcode classification helpers: op_needs_a, op_needs_b, op_legal
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SUBBA = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_DIV   = 4'd4;
    localparam logic [3:0] OP_DIVBA = 4'd5;
    localparam logic [3:0] OP_INC_A = 4'd6;
    localparam logic [3:0] OP_INC_B = 4'd7;
    localparam logic [3:0] OP_CLR   = 4'd8;
    localparam logic [3:0] OP_ACCUM = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_OP,
        ST_SEND_A_MSB,
        ST_SEND_A_LSB,
        ST_SEND_B_MSB,
        ST_SEND_B_LSB,
        ST_WAIT_RDY,
        ST_RESP
    } cmd_state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_ACCUM;
    endfunction

    // Operand A travels for the two-operand ops plus INC_A and ACCUM.
    function automatic logic op_needs_a(input logic [3:0] op);
        return (op <= OP_DIVBA) || (op == OP_INC_A) || (op == OP_ACCUM);
    endfunction

    // Operand B travels for the two-operand ops plus INC_B.
    function automatic logic op_needs_b(input logic [3:0] op);
        return (op <= OP_DIVBA) || (op == OP_INC_B);
    endfunction

endpackage

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: initiator side of the ALU byte-serial command bus.
//   Accepts a command on the req_* valid/ready port, serialises the opcode byte
//   (ctl=1) and the needed operand bytes MSB-first onto alu_ctl/alu_dat, waits
//   (watchdog-bounded) for the ALU's one-cycle alu_ready strobe, then returns
//   the captured alu_result on the rsp_* valid/ready port.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           command handshake; req_op/a/b/k/c payload
//   rsp_valid/rsp_ready           response handshake; rsp_result/err/op payload
//   alu_ctl/alu_dat               command bus byte lane (ctl=1 on opcode byte)
//   alu_k_val/alu_c_val           k and c, held from accept until next accept
//   alu_ready/alu_result          result strobe and value from the ALU
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [7:0]  req_k,
    input  logic [7:0]  req_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic [3:0]  rsp_op,
    output logic        alu_ctl,
    output logic [7:0]  alu_dat,
    output logic [7:0]  alu_k_val,
    output logic [7:0]  alu_c_val,
    input  logic        alu_ready,
    input  logic [31:0] alu_result
);

    cmd_state_e        r_state;
    cmd_state_e        w_next;
    logic [3:0]        r_op;
    logic [15:0]       r_a;
    logic [15:0]       r_b;
    logic [TO_W-1:0]   r_wd;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_result;
    logic              r_rsp_err;
    logic [3:0]        r_rsp_op;
    logic              r_alu_ctl;
    logic [7:0]        r_alu_dat;
    logic [7:0]        r_alu_k;
    logic [7:0]        r_alu_c;

    logic              w_accept;
    logic              w_timeout;
    logic              w_got_rdy;
    logic [7:0]        w_dat_nx;

    assign w_accept  = req_valid & r_req_ready;
    assign w_got_rdy = (r_state == ST_WAIT_RDY) & alu_ready;
    assign w_timeout = (r_state == ST_WAIT_RDY) & (r_wd == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:
                if (w_accept) w_next = op_legal(req_op) ? ST_SEND_OP : ST_RESP;
            ST_SEND_OP:
                if (op_needs_a(r_op))      w_next = ST_SEND_A_MSB;
                else if (op_needs_b(r_op)) w_next = ST_SEND_B_MSB;
                else                       w_next = ST_WAIT_RDY;
            ST_SEND_A_MSB: w_next = ST_SEND_A_LSB;
            ST_SEND_A_LSB: w_next = op_needs_b(r_op) ? ST_SEND_B_MSB : ST_WAIT_RDY;
            ST_SEND_B_MSB: w_next = ST_SEND_B_LSB;
            ST_SEND_B_LSB: w_next = ST_WAIT_RDY;
            ST_WAIT_RDY:
                if (alu_ready || w_timeout) w_next = ST_RESP;
            ST_RESP:
                if (rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Bus outputs are registered, so the byte is chosen from the state being
    // entered. The opcode byte is only entered from IDLE on accept, hence req_op.
    always_comb begin
        w_dat_nx = '0;
        unique case (w_next)
            ST_SEND_OP:    w_dat_nx = {4'h0, req_op};
            ST_SEND_A_MSB: w_dat_nx = r_a[15:8];
            ST_SEND_A_LSB: w_dat_nx = r_a[7:0];
            ST_SEND_B_MSB: w_dat_nx = r_b[15:8];
            ST_SEND_B_LSB: w_dat_nx = r_b[7:0];
            default:       w_dat_nx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_wd         <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_op     <= '0;
            r_alu_ctl    <= 1'b0;
            r_alu_dat    <= '0;
            r_alu_k      <= '0;
            r_alu_c      <= '0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == ST_IDLE);
            r_rsp_valid <= (w_next == ST_RESP);
            r_alu_ctl   <= (w_next == ST_SEND_OP);
            r_alu_dat   <= w_dat_nx;
            // Zero outside WAIT_RDY, so the count always starts at 0 on entry.
            r_wd        <= (r_state == ST_WAIT_RDY) ? r_wd + 1'b1 : '0;
            if (w_accept) begin
                r_op    <= req_op;
                r_a     <= req_a;
                r_b     <= req_b;
                r_alu_k <= req_k;
                r_alu_c <= req_c;
            end
            // Response payload is written once, on RESP entry, and then held.
            if ((w_next == ST_RESP) && (r_state != ST_RESP)) begin
                r_rsp_op     <= (r_state == ST_IDLE) ? req_op : r_op;
                r_rsp_err    <= ~w_got_rdy;
                r_rsp_result <= w_got_rdy ? alu_result : '0;
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;
    assign rsp_op     = r_rsp_op;
    assign alu_ctl    = r_alu_ctl;
    assign alu_dat    = r_alu_dat;
    assign alu_k_val  = r_alu_k;
    assign alu_c_val  = r_alu_c;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: drives alu_cmd_driver with directed and random commands,
// plays the ALU side as a stub (chosen ready delay and result), and checks the
// bus bytes and responses against a byte-list / result reference model.
module tb_alu_cmd_driver;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  req_k;
    logic [7:0]  req_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [3:0]  rsp_op;
    logic        alu_ctl;
    logic [7:0]  alu_dat;
    logic [7:0]  alu_k_val;
    logic [7:0]  alu_c_val;
    logic        alu_ready;
    logic [31:0] alu_result;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.TIMEOUT_CYC(TMO), .TO_W(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_k      (req_k),
        .req_c      (req_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .rsp_op     (rsp_op),
        .alu_ctl    (alu_ctl),
        .alu_dat    (alu_dat),
        .alu_k_val  (alu_k_val),
        .alu_c_val  (alu_c_val),
        .alu_ready  (alu_ready),
        .alu_result (alu_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference byte list: opcode byte, then whichever operands the op uses.
    task automatic model_bytes(input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, output logic [7:0] q[$]);
        int unsigned nbytes;
        q = {};
        if (op > 4'd9) return;
        nbytes = (op <= 4'd5) ? 5 : (op == 4'd8) ? 1 : 3;
        q.push_back({4'h0, op});
        if (nbytes == 5) begin
            q.push_back(a[15:8]); q.push_back(a[7:0]);
            q.push_back(b[15:8]); q.push_back(b[7:0]);
        end else if (nbytes == 3) begin
            if (op == 4'd7) begin q.push_back(b[15:8]); q.push_back(b[7:0]); end
            else            begin q.push_back(a[15:8]); q.push_back(a[7:0]); end
        end
    endtask

    // d = WAIT_RDY cycle (0-based) in which the stub pulses alu_ready.
    task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [7:0] k, input logic [7:0] c, input int unsigned d,
                           input logic [31:0] res, input int unsigned hold);
        logic [7:0]  q[$];
        logic        exp_err;
        logic [31:0] exp_res;
        model_bytes(op, a, b, q);
        exp_err = (op > 4'd9) || (d > TMO - 1);
        exp_res = exp_err ? 32'h0 : res;

        chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_k = k; req_c = c;
        @(negedge clk);
        req_valid = 1'b0; req_op = $urandom; req_a = $urandom; req_b = $urandom;
        req_k = $urandom; req_c = $urandom;

        foreach (q[i]) begin
            chk("bus_ctl", {31'h0, alu_ctl}, {31'h0, (i == 0)});
            chk("bus_dat", {24'h0, alu_dat}, {24'h0, q[i]});
            chk("k_val",   {24'h0, alu_k_val}, {24'h0, k});
            chk("c_val",   {24'h0, alu_c_val}, {24'h0, c});
            chk("req_ready_busy", {31'h0, req_ready}, 32'h0);
            @(negedge clk);
        end

        if (op <= 4'd9) begin
            for (int unsigned w = 0; w < TMO; w++) begin
                chk("wait_ctl",  {31'h0, alu_ctl}, 32'h0);
                chk("wait_dat",  {24'h0, alu_dat}, 32'h0);
                chk("wait_rsp",  {31'h0, rsp_valid}, 32'h0);
                if (w == d) begin alu_ready = 1'b1; alu_result = res; end
                @(negedge clk);
                alu_ready = 1'b0; alu_result = $urandom;
                if (w == d) break;
            end
        end

        for (int unsigned h = 0; h <= hold; h++) begin
            chk("rsp_valid",  {31'h0, rsp_valid}, 32'h1);
            chk("rsp_err",    {31'h0, rsp_err}, {31'h0, exp_err});
            chk("rsp_result", rsp_result, exp_res);
            chk("rsp_op",     {28'h0, rsp_op}, {28'h0, op});
            chk("req_ready_resp", {31'h0, req_ready}, 32'h0);
            chk("resp_ctl",   {31'h0, alu_ctl}, 32'h0);
            if (h == hold) rsp_ready = 1'b1;
            else begin
                // Late / unsolicited strobes must not disturb the held response.
                alu_ready = $urandom_range(0, 1); alu_result = $urandom;
            end
            @(negedge clk);
            alu_ready = 1'b0;
        end
        rsp_ready = 1'b0;
        chk("rsp_done", {31'h0, rsp_valid}, 32'h0);
        chk("req_ready_back", {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        req_k = '0; req_c = '0; rsp_ready = 1'b0; alu_ready = 1'b0; alu_result = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid",  {31'h0, rsp_valid}, 32'h0);
        chk("rst_ctl",        {31'h0, alu_ctl}, 32'h0);
        chk("rst_dat",        {24'h0, alu_dat}, 32'h0);
        chk("rst_result",     rsp_result, 32'h0);
        chk("rst_kc",         {16'h0, alu_k_val, alu_c_val}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(4'd0, 16'h0003, 16'h0005, 8'd2, 8'd1, 2,  32'h11,  0);
        run_cmd(4'd7, 16'h1234, 16'h00FF, 8'd1, 8'd0, 0,  32'h100, 1);
        run_cmd(4'd8, 16'hAAAA, 16'h5555, 8'd0, 8'd0, 1,  32'h0,   0);
        run_cmd(4'hA, 16'h1111, 16'h2222, 8'd3, 8'd4, 0,  32'h0,   0);
        run_cmd(4'd3, 16'hBEEF, 16'hCAFE, 8'd5, 8'd6, 99, 32'hDEAD, 3);
        run_cmd(4'd9, 16'h8001, 16'h0000, 8'd7, 8'd8, TMO - 1, 32'hCAFE_F00D, 10);
        run_cmd(4'd6, 16'hFFFF, 16'h0000, 8'd9, 8'd9, TMO, 32'h1, 1);

        // Reset while the A LSB byte is on the bus: command dropped.
        req_valid = 1'b1; req_op = 4'd0; req_a = 16'h1234; req_b = 16'h5678;
        req_k = 8'h11; req_c = 8'h22;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_dat", {24'h0, alu_dat}, 32'h34);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ctl",   {31'h0, alu_ctl}, 32'h0);
        chk("mid_rst_dat",   {24'h0, alu_dat}, 32'h0);
        chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
        chk("mid_rst_rsp",   {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        chk("post_rst_rsp",  {31'h0, rsp_valid}, 32'h0);

        for (int i = 0; i < 40; i++) begin
            run_cmd(4'($urandom_range(0, 11)), 16'($urandom), 16'($urandom),
                    8'($urandom), 8'($urandom), $urandom_range(0, TMO + 3),
                    $urandom, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
